uart_full_duplex: RTL and testbench
===================================

UART_FULL_DUPLEX -- requirements
Module: uart_full_duplex

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_serial  input  1  serial receive line; idle high.
REQ-005 tx_serial  output  1  serial transmit line; idle high.
REQ-006 tx_start  input  1  transmit request, sampled only while the transmitter is idle.
REQ-007 tx_data  input  8  byte to transmit, captured on an accepted tx_start.
REQ-008 tx_active  output  1  high while a frame is being transmitted.
REQ-009 tx_done  output  1  one-cycle pulse at end of a transmitted frame.
REQ-010 rx_dv  output  1  one-cycle pulse when a valid byte is received.
REQ-011 rx_data  output  8  last received byte; held until the next valid byte.

Function
REQ-012 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-013 TX states SHALL be IDLE, START, DATA, STOP, DONE; IDLE->START on tx_start=1; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after bit index 7 completes; STOP->DONE after CLKS_PER_BIT cycles; DONE->IDLE after one cycle.
REQ-014 On the clock edge where tx_start=1 in IDLE, tx_data SHALL be latched and tx_active and tx_serial=0 SHALL take effect on that same edge.
REQ-015 tx_active SHALL stay high through START, DATA and STOP and drop on the DONE edge.
REQ-016 tx_done SHALL be high for exactly the single DONE cycle.
REQ-017 tx_start and tx_data changes SHALL be ignored while not in IDLE; tx_start held high SHALL start a new frame on the first IDLE cycle after DONE, giving back-to-back frames.
REQ-018 rx_serial SHALL pass through a 2-flop synchronizer before use.
REQ-019 RX states SHALL be IDLE, START, DATA, STOP, CLEANUP; IDLE->START when the synchronized line is 0.
REQ-020 In START, the line SHALL be resampled at CLKS_PER_BIT/2 cycles (integer divide); if 1 (glitch), return to IDLE with no output.
REQ-021 Each data bit SHALL be sampled CLKS_PER_BIT cycles after the previous sample point and shifted in LSB first.
REQ-022 Stop bit SHALL be sampled one bit time after data bit 7; if 1, rx_data SHALL update and rx_dv SHALL pulse one cycle on the same edge; if 0 (framing error), the byte SHALL be discarded, rx_data unchanged, no rx_dv.
REQ-023 CLEANUP SHALL last one cycle, then IDLE; the receiver SHALL then wait for line high before arming a new start.
REQ-024 Transmitter and receiver SHALL operate fully independently and concurrently.

Reset
REQ-025 While reset is high: tx_serial=1, tx_active=0, tx_done=0, rx_dv=0, rx_data=8'h00, both FSMs IDLE, all counters and shift registers 0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL abort both directions immediately with no tx_done or rx_dv pulse; operation resumes from IDLE on the first edge after release.

Configuration
REQ-027 Macro UART_LOOPBACK_EN: when defined, the receiver input SHALL be internally driven by the transmitter output (rx_serial ignored) and tx_serial still driven; when undefined, the receiver SHALL use rx_serial.

Verification
REQ-028 Reset held 5 cycles, rx_serial=1 -> tx_serial=1, tx_active=0, tx_done=0, rx_dv=0, rx_data=8'h00.
REQ-029 tx_start pulse with tx_data=8'h48, CLKS_PER_BIT=16 -> tx_serial sequence 0,0,0,0,1,0,0,1,0,1 per 16 cycles; tx_done pulse exactly 160 cycles after acceptance; tx_active low after it.
REQ-030 UART_LOOPBACK_EN defined, tx_start held high with tx_data 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F presented each frame -> five rx_dv pulses with rx_data 48,65,6C,6C,6F in order.
REQ-031 Drive rx_serial frame 8'hA5 with stop bit 0 -> no rx_dv, rx_data unchanged; following valid 8'h3C -> rx_dv with rx_data=8'h3C.
REQ-032 rx_serial low pulse of 3 cycles, then high -> no rx_dv, receiver back in IDLE; next valid frame 8'h55 received correctly.
REQ-033 Reset asserted at data bit 4 of a transmit frame -> tx_serial=1 and tx_active=0 immediately, no tx_done.

Source files
------------

// File: rtl/uart_full_duplex.sv
// uart_full_duplex: independent 8N1 UART transmitter and receiver; define UART_LOOPBACK_EN to feed the receiver from tx_serial.
module uart_full_duplex #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       tx_serial,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_active,
  output logic       tx_done,
  output logic       rx_dv,
  output logic [7:0] rx_data
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP} rx_state_t;

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_serial_n, tx_active_n, tx_done_n;
  logic        tx_last;

  assign tx_last = tx_cnt == LAST;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_idx    <= tx_idx_n;
      tx_shift  <= tx_shift_n;
      tx_serial <= tx_serial_n;
      tx_active <= tx_active_n;
      tx_done   <= tx_done_n;
    end

  always_comb begin
    tx_state_n  = tx_state;
    tx_idx_n    = tx_idx;
    tx_shift_n  = tx_shift;
    tx_serial_n = tx_serial;
    tx_active_n = tx_active;
    tx_done_n   = 1'b0;
    tx_cnt_n    = (tx_last || tx_state == TX_IDLE || tx_state == TX_DONE) ? '0 : tx_cnt + 16'd1;
    case (tx_state)
      TX_IDLE:
        if (tx_start) begin
          tx_state_n  = TX_START;
          tx_shift_n  = tx_data;
          tx_serial_n = 1'b0;
          tx_active_n = 1'b1;
          tx_idx_n    = '0;
        end
      TX_START:
        if (tx_last) begin
          tx_state_n  = TX_DATA;
          tx_serial_n = tx_shift[0];
        end
      TX_DATA:
        if (tx_last) begin
          tx_shift_n  = {1'b0, tx_shift[7:1]};
          tx_idx_n    = tx_idx + 3'd1;
          tx_serial_n = (tx_idx == 3'd7) ? 1'b1 : tx_shift[1];
          tx_state_n  = (tx_idx == 3'd7) ? TX_STOP : TX_DATA;
        end
      TX_STOP:
        if (tx_last) begin
          tx_state_n  = TX_DONE;
          tx_active_n = 1'b0;
          tx_done_n   = 1'b1;
        end
      TX_DONE: tx_state_n = TX_IDLE;
      default: tx_state_n = TX_IDLE;
    endcase
  end

  logic rx_in;
`ifdef UART_LOOPBACK_EN
  logic unused_rx_serial;
  assign unused_rx_serial = rx_serial;
  assign rx_in = tx_serial;
`else
  assign rx_in = rx_serial;
`endif

  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clk or posedge reset)
    if (reset) rx_sync <= 2'b11;
    else rx_sync <= {rx_sync[0], rx_in};

  assign rx_s = rx_sync[1];

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic [7:0]  rx_data_n;
  logic        rx_dv_n, rx_armed, rx_armed_n;
  logic        rx_last, rx_half;

  assign rx_last = rx_cnt == LAST;
  assign rx_half = rx_cnt == HALF;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_armed <= 1'b0;
      rx_dv    <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_armed <= rx_armed_n;
      rx_dv    <= rx_dv_n;
      rx_data  <= rx_data_n;
    end

  // START counts to mid-bit; every later state counts whole bit periods from that point.
  always_comb begin
    rx_state_n = rx_state;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_armed_n = rx_armed;
    rx_data_n  = rx_data;
    rx_dv_n    = 1'b0;
    rx_cnt_n   = ((rx_state == RX_START ? rx_half : rx_last) || rx_state == RX_IDLE || rx_state == RX_CLEANUP)
                 ? '0 : rx_cnt + 16'd1;
    case (rx_state)
      RX_IDLE: begin
        rx_armed_n = rx_armed | rx_s;
        if (rx_armed && !rx_s) rx_state_n = RX_START;
      end
      RX_START:
        if (rx_half) begin
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
          rx_idx_n   = '0;
        end
      RX_DATA:
        if (rx_last) begin
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_idx_n   = rx_idx + 3'd1;
          rx_state_n = (rx_idx == 3'd7) ? RX_STOP : RX_DATA;
        end
      RX_STOP:
        if (rx_last) begin
          rx_state_n = RX_CLEANUP;
          rx_armed_n = 1'b0;
          rx_data_n  = rx_s ? rx_shift : rx_data;
          rx_dv_n    = rx_s;
        end
      RX_CLEANUP: rx_state_n = RX_IDLE;
      default:    rx_state_n = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_full_duplex.sv
// tb_uart_full_duplex: directed UART vectors checked against a frame-level model every cycle.
module tb_uart_full_duplex;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_serial;
  logic       tx_serial;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_active;
  logic       tx_done;
  logic       rx_dv;
  logic [7:0] rx_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rx_serial = loop ? tx_serial : rx_drv;

  uart_full_duplex #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rx_serial(rx_serial), .tx_serial(tx_serial),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done),
    .rx_dv(rx_dv), .rx_data(rx_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: cycles since the accepting edge index straight into the 10-bit frame.
  int         tcount = -1;
  logic [7:0] tbyte = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last = 8'h00;

  always @(posedge clk or posedge reset)
    if (reset) begin
      tcount = -1;
      exp_q.delete();
      exp_last = 8'h00;
    end else if (tcount < 0) begin
      if (tx_start) begin
        tcount = 0;
        tbyte = tx_data;
      end
    end else if (tcount == 10 * C) tcount = -1;
    else tcount++;

  logic       es, ea, ed;
  int         bi;
  logic [7:0] eb;

  always @(negedge clk) begin
    es = 1'b1;
    ea = 1'b0;
    ed = 1'b0;
    if (tcount >= 0 && tcount < 10 * C) begin
      ea = 1'b1;
      bi = tcount / C;
      es = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : tbyte[bi-1];
    end else if (tcount == 10 * C) ed = 1'b1;
    chk("tx_serial", tx_serial, es);
    chk("tx_active", tx_active, ea);
    chk("tx_done", tx_done, ed);
    if (rx_dv) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_dv_unexpected: got rx_dv=1 rx_data=%0h expected no pulse at %0t", rx_data, $time);
      end else begin
        eb = exp_q.pop_front();
        chk("rx_byte", rx_data, eb);
        exp_last = eb;
      end
    end else chk("rx_data_hold", rx_data, exp_last);
  end

  task automatic wait_done();
    int n = 0;
    while (!tx_done && n < 400) begin
      tick();
      n++;
    end
    chk("tx_done_timeout", 32'(n < 400), 1);
  endtask

  task automatic wait_rx();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("rx_pending", exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    rx_drv = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (C) tick();
    end
    rx_drv = stop;
    repeat (C) tick();
    rx_drv = 1'b1;
    repeat (2 * C) tick();
    chk("rx_pending", exp_q.size(), 0);
  endtask

  int          lit[10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
  logic [7:0]  hello[5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  int          cyc;

  initial begin
    repeat (5) tick();
    chk("rst_tx_serial", tx_serial, 1);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_rx_dv", rx_dv, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (3) tick();

    tx_data = 8'h48;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data = 8'hFF;
    cyc = 0;
    while (!tx_done && cyc < 400) begin
      if (cyc % C == C / 2 && cyc < 10 * C) chk("tx_bit_48", tx_serial, lit[cyc/C]);
      tick();
      cyc++;
    end
    chk("tx_done_latency", cyc, 160);
    tick();
    chk("tx_active_after", tx_active, 0);
    chk("tx_done_width", tx_done, 0);
    repeat (4) tick();

    loop = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(hello[i]);
    tx_data = hello[0];
    tx_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_done();
      if (i < 4) tx_data = hello[i+1];
      else tx_start = 1'b0;
      tick();
    end
    wait_rx();
    chk("loop_last", rx_data, 8'h6F);
    repeat (4) tick();
    loop = 1'b0;
    repeat (4) tick();

    send_frame(8'hA5, 1'b0);
    chk("frame_err_hold", rx_data, 8'h6F);
    send_frame(8'h3C, 1'b1);
    chk("after_frame_err", rx_data, 8'h3C);

    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    repeat (2 * C) tick();
    chk("glitch_hold", rx_data, 8'h3C);
    send_frame(8'h55, 1'b1);
    chk("after_glitch", rx_data, 8'h55);

    tx_data = 8'hC3;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (5 * C + C / 2 - 1) tick();
    chk("mid_bit4_active", tx_active, 1);
    reset = 1'b1;
    #1;
    chk("abort_tx_serial", tx_serial, 1);
    chk("abort_tx_active", tx_active, 0);
    repeat (3) tick();
    reset = 1'b0;
    chk("abort_rx_data", rx_data, 8'h00);
    repeat (2) tick();

    loop = 1'b1;
    exp_q.push_back(8'h5A);
    tx_data = 8'h5A;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    wait_done();
    wait_rx();
    chk("resume_rx", rx_data, 8'h5A);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
